// File: rtl/sr194_sequencer_if.sv
// Command request channel for sr194_sequencer: valid/ready handshake carrying op, data and shift count.
// The requester side uses the master modport, the sequencer uses slave.
interface sr194_sequencer_if #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 3
);
   logic              valid;
   logic              ready;
   logic [2:0]        op;
   logic [DATA_W-1:0] data;
   logic [CNT_W-1:0]  cnt;

   modport master (output valid, output op, output data, output cnt, input ready);
   modport slave  (input valid, input op, input data, input cnt, output ready);
endinterface

// File: rtl/sr194_sequencer.sv
// Command sequencer for a 74194-style universal shift register: drives MR/S/D/DSR/DSL/CE per command.
// Optional second requester with round-robin arbitration when SR194_SEQ_ARB2_EN is defined.
module sr194_sequencer #(
   parameter int DATA_W     = 4,
   parameter int CNT_W      = 3,
   parameter int CLR_CYCLES = 1
) (
   input  logic              sysclk,
   input  logic              sysreset,
   sr194_sequencer_if.slave  req,
`ifdef SR194_SEQ_ARB2_EN
   sr194_sequencer_if.slave  req2,
   output logic              gnt,
`endif
   input  logic [DATA_W-1:0] q_fb,
   output logic              sr_mr,
   output logic [1:0]        sr_s,
   output logic [DATA_W-1:0] sr_d,
   output logic              sr_dsr,
   output logic              sr_dsl,
   output logic              sr_ce,
   output logic              busy,
   output logic              done
);

   localparam int CLR_W = $clog2(CLR_CYCLES + 1);
   localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES);

   typedef enum logic [2:0] {
      OP_NOP, OP_CLEAR, OP_LOAD, OP_SHR, OP_SHL, OP_ROTR, OP_ROTL, OP_NOP7
   } op_e;

   typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, FIN} state_e;

   state_e            state, state_n;
   op_e               op_r, op_n;
   logic [DATA_W-1:0] data_r, data_n;
   logic              fill_r, fill_n;
   logic [CNT_W-1:0]  cnt_r, cnt_n;
   logic [CLR_W-1:0]  clr_r, clr_n;

   logic              rdy_r, rdy_n;
   logic              mr_n, ce_n, busy_n, done_n;
   logic [1:0]        s_n;
   logic [DATA_W-1:0] d_n;
   logic              dsr_r, dsr_n, dsl_r, dsl_n;
   logic              rotr_r, rotr_n, rotl_r, rotl_n;
   logic              q_msb, q_lsb;

   logic              sel_valid;
   logic [2:0]        sel_op;
   logic [DATA_W-1:0] sel_data;
   logic [CNT_W-1:0]  sel_cnt;
   logic              accept;

`ifdef SR194_SEQ_ARB2_EN
   logic last_r, pick;

   // last_r resets to 1 so requester 1 wins the first simultaneous request
   always_comb begin
      pick = 1'b0;
      if (req.valid && req2.valid) pick = ~last_r;
      else if (req2.valid)         pick = 1'b1;
      sel_valid = pick ? req2.valid : req.valid;
      sel_op    = pick ? req2.op    : req.op;
      sel_data  = pick ? req2.data  : req.data;
      sel_cnt   = pick ? req2.cnt   : req.cnt;
   end

   assign req.ready  = rdy_r & ~pick;
   assign req2.ready = rdy_r & pick;

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         gnt    <= 1'b0;
         last_r <= 1'b1;
      end else if (accept) begin
         gnt    <= pick;
         last_r <= pick;
      end
   end
`else
   always_comb begin
      sel_valid = req.valid;
      sel_op    = req.op;
      sel_data  = req.data;
      sel_cnt   = req.cnt;
   end

   assign req.ready = rdy_r;
`endif

   // rdy_r is only ever high in IDLE, so accept implies IDLE
   assign accept = rdy_r & sel_valid;

   always_comb begin
      state_n = state;
      op_n    = op_r;
      data_n  = data_r;
      fill_n  = fill_r;
      cnt_n   = cnt_r;
      clr_n   = clr_r;
      unique case (state)
         IDLE: begin
            if (accept) begin
               op_n   = op_e'(sel_op);
               data_n = sel_data;
               fill_n = sel_data[0];
               cnt_n  = sel_cnt;
               clr_n  = CLR_LOAD;
               case (op_n)
                  OP_CLEAR: state_n = CLR;
                  OP_LOAD:  state_n = LOAD;
                  OP_SHR, OP_SHL, OP_ROTR, OP_ROTL:
                     state_n = (sel_cnt == '0) ? FIN : SHIFT;
                  default:  state_n = FIN;
               endcase
            end
         end
         CLR: begin
            clr_n = clr_r - CLR_W'(1);
            if (clr_r <= CLR_W'(1)) state_n = FIN;
         end
         LOAD: state_n = FIN;
         SHIFT: begin
            if (cnt_r != '0) cnt_n = cnt_r - CNT_W'(1);
            if (cnt_r <= CNT_W'(1)) state_n = FIN;
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Pin values are decoded from the next state so they appear registered in the state they belong to
   always_comb begin
      mr_n   = (state_n != CLR);
      ce_n   = (state_n == LOAD) || (state_n == SHIFT);
      s_n    = 2'b00;
      if (state_n == LOAD) s_n = 2'b11;
      else if (state_n == SHIFT) s_n = (op_n == OP_SHR || op_n == OP_ROTR) ? 2'b01 : 2'b10;
      d_n    = (state_n == LOAD) ? data_n : '0;
      dsr_n  = (state_n == SHIFT) && (op_n == OP_SHR) && fill_n;
      dsl_n  = (state_n == SHIFT) && (op_n == OP_SHL) && fill_n;
      rotr_n = (state_n == SHIFT) && (op_n == OP_ROTR);
      rotl_n = (state_n == SHIFT) && (op_n == OP_ROTL);
      busy_n = (state_n != IDLE);
      done_n = (state_n == FIN);
      rdy_n  = (state_n == IDLE);
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state  <= IDLE;
         op_r   <= OP_NOP;
         data_r <= '0;
         fill_r <= 1'b0;
         cnt_r  <= '0;
         clr_r  <= '0;
         rdy_r  <= 1'b0;
         sr_mr  <= 1'b1;
         sr_s   <= 2'b00;
         sr_d   <= '0;
         dsr_r  <= 1'b0;
         dsl_r  <= 1'b0;
         rotr_r <= 1'b0;
         rotl_r <= 1'b0;
         sr_ce  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         op_r   <= op_n;
         data_r <= data_n;
         fill_r <= fill_n;
         cnt_r  <= cnt_n;
         clr_r  <= clr_n;
         rdy_r  <= rdy_n;
         sr_mr  <= mr_n;
         sr_s   <= s_n;
         sr_d   <= d_n;
         dsr_r  <= dsr_n;
         dsl_r  <= dsl_n;
         rotr_r <= rotr_n;
         rotl_r <= rotl_n;
         sr_ce  <= ce_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   // Rotate feedback taps the register outputs combinationally
   assign q_msb  = |(q_fb & {1'b1, {(DATA_W-1){1'b0}}});
   assign q_lsb  = |(q_fb & DATA_W'(1));
   assign sr_dsr = rotr_r ? q_msb : dsr_r;
   assign sr_dsl = rotl_r ? q_lsb : dsl_r;

endmodule

// File: tb/tb_sr194_sequencer.sv
// Self-checking bench for sr194_sequencer with a behavioural 74194 attached to the pins.
// Exercises the second requester when SR194_SEQ_ARB2_EN is defined.
module tb_sr194_sequencer;
   localparam int DATA_W     = 4;
   localparam int CNT_W      = 3;
   localparam int CLR_CYCLES = 2;

   logic sysclk = 1'b0;
   logic sysreset = 1'b1;
   always #5 sysclk = ~sysclk;

   sr194_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) req ();
`ifdef SR194_SEQ_ARB2_EN
   sr194_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) req2 ();
   logic gnt;
`endif

   logic [DATA_W-1:0] q_fb = '0;
   logic              sr_mr, sr_dsr, sr_dsl, sr_ce, busy, done;
   logic [1:0]        sr_s;
   logic [DATA_W-1:0] sr_d;

   sr194_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .CLR_CYCLES(CLR_CYCLES)) dut (
      .sysclk   (sysclk),
      .sysreset (sysreset),
      .req      (req),
`ifdef SR194_SEQ_ARB2_EN
      .req2     (req2),
      .gnt      (gnt),
`endif
      .q_fb     (q_fb),
      .sr_mr    (sr_mr),
      .sr_s     (sr_s),
      .sr_d     (sr_d),
      .sr_dsr   (sr_dsr),
      .sr_dsl   (sr_dsl),
      .sr_ce    (sr_ce),
      .busy     (busy),
      .done     (done)
   );

   // 74194 device model: async clear, clocked update gated by CE
   always @(posedge sysclk or negedge sr_mr) begin
      if (!sr_mr) q_fb <= '0;
      else if (sr_ce) begin
         case (sr_s)
            2'b01:   q_fb <= {q_fb[2:0], sr_dsr};
            2'b10:   q_fb <= {sr_dsl, q_fb[3:1]};
            2'b11:   q_fb <= sr_d;
            default: q_fb <= q_fb;
         endcase
      end
   end

   int checks = 0;
   int errors = 0;
   int exp_q  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int latency(input int op, input int cnt);
      case (op)
         1:          return CLR_CYCLES + 1;
         2:          return 2;
         3, 4, 5, 6: return (cnt == 0) ? 1 : cnt + 1;
         default:    return 1;
      endcase
   endfunction

   // One shift step; bit i of q is Q[i], "right" moves bits toward higher index
   function automatic int step(input int op, input int q, input int fill);
      case (op)
         3:       return ((q << 1) | fill) & 15;
         4:       return (q >> 1) | (fill << 3);
         5:       return ((q << 1) | (q >> 3)) & 15;
         6:       return (q >> 1) | ((q & 1) << 3);
         default: return q;
      endcase
   endfunction

   task automatic scramble();
      req.op   = 3'($urandom_range(0, 7));
      req.data = 4'($urandom_range(0, 15));
      req.cnt  = 3'($urandom_range(0, 7));
   endtask

   task automatic run_cmd(input int op, input int data, input int cnt, input bit hold);
      int lat;
      int w;
      int fill;
      req.valid = 1'b1;
      req.op    = 3'(op);
      req.data  = 4'(data);
      req.cnt   = 3'(cnt);
      fill      = data & 1;
      w = 0;
      while (req.ready !== 1'b1 && w < 20) begin
         @(negedge sysclk);
         w++;
      end
      chk("ready_wait", req.ready, 1);
      lat = latency(op, cnt);
      @(negedge sysclk);
      if (hold) scramble();
      else req.valid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         if (k < lat) begin
            chk("busy_ready", req.ready, 0);
            chk("busy", busy, 1);
            chk("busy_done", done, 0);
            case (op)
               1: begin
                  chk("clr_mr", sr_mr, 0);
                  chk("clr_ce", sr_ce, 0);
               end
               2: begin
                  chk("load_s", sr_s, 3);
                  chk("load_ce", sr_ce, 1);
                  chk("load_d", sr_d, data);
               end
               default: begin
                  chk("shift_s", sr_s, (op == 3 || op == 5) ? 1 : 2);
                  chk("shift_ce", sr_ce, 1);
                  case (op)
                     3: chk("shr_dsr", sr_dsr, fill);
                     4: chk("shl_dsl", sr_dsl, fill);
                     5: chk("rotr_dsr", sr_dsr, (exp_q >> 3) & 1);
                     default: chk("rotl_dsl", sr_dsl, exp_q & 1);
                  endcase
                  exp_q = step(op, exp_q, fill);
               end
            endcase
         end else begin
            chk("fin_done", done, 1);
            chk("fin_ce", sr_ce, 0);
            chk("fin_s", sr_s, 0);
            chk("fin_mr", sr_mr, 1);
            chk("fin_ready", req.ready, 0);
         end
         if (hold) scramble();
         @(negedge sysclk);
      end
      if (op == 1) exp_q = 0;
      if (op == 2) exp_q = data;
      chk("after_ready", req.ready, 1);
      chk("after_done", done, 0);
      chk("reg_q", q_fb, exp_q);
   endtask

   initial begin
      req.valid = 1'b0;
      req.op    = '0;
      req.data  = '0;
      req.cnt   = '0;
`ifdef SR194_SEQ_ARB2_EN
      req2.valid = 1'b0;
      req2.op    = '0;
      req2.data  = '0;
      req2.cnt   = '0;
`endif
      repeat (3) @(negedge sysclk);
      chk("rst_ready", req.ready, 0);
      chk("rst_mr", sr_mr, 1);
      chk("rst_s", sr_s, 0);
      chk("rst_d", sr_d, 0);
      chk("rst_dsr", sr_dsr, 0);
      chk("rst_dsl", sr_dsl, 0);
      chk("rst_ce", sr_ce, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      sysreset = 1'b0;
      @(negedge sysclk);
      chk("first_ready", req.ready, 1);

      run_cmd(2, 4'hA, 0, 1'b0);      // LOAD A
      run_cmd(1, 0, 0, 1'b0);         // CLEAR, MR low CLR_CYCLES cycles
      run_cmd(3, 1, 3, 1'b0);         // SHR x3 fill 1 -> 7
      run_cmd(2, 9, 0, 1'b0);         // LOAD 9
      run_cmd(6, 0, 1, 1'b0);         // ROTL x1 -> C
      run_cmd(5, 0, 3, 1'b0);         // ROTR x3
      run_cmd(4, 0, 0, 1'b0);         // SHL cnt 0: direct to FIN
      run_cmd(3, 0, 7, 1'b1);         // SHR x7 with VALID held
      run_cmd(2, 4'h5, 0, 1'b0);      // the held request, accepted right after DONE
      run_cmd(0, 0, 5, 1'b0);
      run_cmd(7, 4'hF, 5, 1'b0);

      // Reset in the third cycle of a long shift
      req.valid = 1'b1;
      req.op    = 3'd3;
      req.data  = 4'h1;
      req.cnt   = 3'd7;
      chk("mid_ready", req.ready, 1);
      @(negedge sysclk);
      req.valid = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         chk("mid_ce", sr_ce, 1);
         exp_q = step(3, exp_q, 1);
         @(negedge sysclk);
      end
      #2 sysreset = 1'b1;
      #1;
      chk("abort_ready", req.ready, 0);
      chk("abort_mr", sr_mr, 1);
      chk("abort_s", sr_s, 0);
      chk("abort_d", sr_d, 0);
      chk("abort_dsr", sr_dsr, 0);
      chk("abort_dsl", sr_dsl, 0);
      chk("abort_ce", sr_ce, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge sysclk);
      chk("abort_done2", done, 0);
      sysreset = 1'b0;
      chk("abort_q", q_fb, exp_q);
      @(negedge sysclk);
      chk("abort_ready2", req.ready, 1);
      chk("abort_done3", done, 0);

      for (int n = 0; n < 25; n++)
         run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), 1'b0);

`ifdef SR194_SEQ_ARB2_EN
      // Both requesters post NOPs; grants must alternate starting with requester 1
      req.op     = 3'd0;
      req2.op    = 3'd0;
      req.valid  = 1'b1;
      req2.valid = 1'b1;
      for (int n = 0; n < 4; n++) begin
         int w;
         w = 0;
         while ((req.ready | req2.ready) !== 1'b1 && w < 20) begin
            @(negedge sysclk);
            w++;
         end
         chk("arb_ready1", req.ready, (n % 2) == 0);
         chk("arb_ready2", req2.ready, (n % 2) == 1);
         @(negedge sysclk);
         chk("arb_gnt", gnt, n % 2);
         chk("arb_done", done, 1);
      end
      req.valid  = 1'b0;
      req2.valid = 1'b0;
      @(negedge sysclk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
